// File: rtl/dip_key_conditioner.sv
// Conditions four slide switches and four push-buttons: 2-flop synchronizers,
// per-bit stable-count debounce, pattern decode and change/press pulses.
module dip_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip,
  input  logic [3:0] P,
  output logic [3:0] dip_clean,
  output logic [1:0] mode,
  output logic       dip_chg,
  output logic [3:0] p_level,
  output logic [3:0] p_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bits [3:0] are switches, bits [7:4] are buttons
  logic [7:0]            sync_p0, sync_p1;
  logic [7:0]            clean_p2, clean_nxt, upd;
  logic [7:0][CNT_W-1:0] cnt_p2, cnt_nxt;

  function automatic logic [1:0] mode_decode(input logic [3:0] v);
    case (v)
      4'b0110: mode_decode = 2'd1;
      4'b1001: mode_decode = 2'd2;
      default: mode_decode = 2'd0;
    endcase
  endfunction

  always_comb begin
    clean_nxt = clean_p2;
    cnt_nxt   = cnt_p2;
    upd       = '0;
    for (int i = 0; i < 8; i++) begin
      if (sync_p1[i] == clean_p2[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_p2[i] == CNT_LAST) begin
        clean_nxt[i] = sync_p1[i];
        cnt_nxt[i]   = '0;
        upd[i]       = 1'b1;
      end else begin
        cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      cnt_p2   <= '0;
      clean_p2 <= '0;
      mode     <= '0;
      dip_chg  <= 1'b0;
      p_press  <= '0;
    end else begin
      // synchronizer stages
      sync_p0  <= {P, dip};
      sync_p1  <= sync_p0;
      // debounce stage; pulses and mode land on the same edge as the clean level
      cnt_p2   <= cnt_nxt;
      clean_p2 <= clean_nxt;
      mode     <= mode_decode(clean_nxt[3:0]);
      dip_chg  <= |upd[3:0];
      p_press  <= upd[7:4] & clean_nxt[7:4];
    end
  end

  assign dip_clean = clean_p2[3:0];
  assign p_level   = clean_p2[7:4];

endmodule

// File: tb/tb_dip_key_conditioner.sv
// Directed bench for dip_key_conditioner with a scoreboard of expected clean
// levels keyed by the edge on which they must appear.
module tb_dip_key_conditioner;

  localparam int D  = 4;
  localparam int CW = 3;
  localparam int LAT = D + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dip, P;
  logic [3:0] dip_clean, p_level, p_press;
  logic [1:0] mode;
  logic       dip_chg;

  always #5 clk = ~clk;

  dip_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dip(dip), .P(P),
    .dip_clean(dip_clean), .mode(mode), .dip_chg(dip_chg),
    .p_level(p_level), .p_press(p_press)
  );

  typedef struct {
    int         at;
    logic [3:0] d;
    logic [3:0] p;
  } ev_t;

  ev_t        sb[$];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_d = '0;
  logic [3:0] exp_p = '0;

  function automatic logic [1:0] exp_mode(input logic [3:0] v);
    if (v == 4'b0110) return 2'd1;
    if (v == 4'b1001) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all(input logic ec, input logic [3:0] epr);
    chk("dip_clean", dip_clean, exp_d);
    chk("mode", {2'b00, mode}, {2'b00, exp_mode(exp_d)});
    chk("dip_chg", {3'b000, dip_chg}, {3'b000, ec});
    chk("p_level", p_level, exp_p);
    chk("p_press", p_press, epr);
  endtask

  task automatic tick();
    ev_t        e;
    logic       ec;
    logic [3:0] epr;
    @(posedge clk);
    #1;
    cyc++;
    ec  = 1'b0;
    epr = '0;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e     = sb.pop_front();
      ec    = (e.d != exp_d);
      epr   = e.p & ~exp_p;
      exp_d = e.d;
      exp_p = e.p;
    end
    check_all(ec, epr);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // apply a level that is held long enough to be accepted
  task automatic drive(input logic [3:0] d, input logic [3:0] p);
    dip = d;
    P   = p;
    sb.push_back('{cyc + LAT, d, p});
  endtask

  initial begin
    dip = '0;
    P   = '0;
    #1 rst = 1'b1;
    #1 check_all(1'b0, 4'b0000);
    ticks(3);
    rst = 1'b0;
    ticks(20);

    // three-cycle glitch on dip[1] is rejected
    dip = 4'b0010;
    ticks(3);
    dip = 4'b0000;
    ticks(10);

    // accepted patterns and decode
    drive(4'b0110, 4'b0000);
    ticks(10);
    drive(4'b1001, 4'b0000);
    ticks(10);
    drive(4'b1111, 4'b0000);
    ticks(10);

    // button held 12 cycles: one press, silent release
    drive(4'b1111, 4'b0100);
    ticks(12);
    drive(4'b1111, 4'b0000);
    ticks(10);

    // simultaneous switch and button events
    drive(4'b0000, 4'b1011);
    ticks(10);
    drive(4'b0000, 4'b0000);
    ticks(10);

    // updates on adjacent edges give two pulses
    drive(4'b0001, 4'b0000);
    ticks(1);
    drive(4'b1001, 4'b0000);
    ticks(10);

    // asynchronous reset in the middle of a debounce
    dip = 4'b0110;
    ticks(2);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_d = '0;
    exp_p = '0;
    check_all(1'b0, 4'b0000);
    ticks(2);
    rst = 1'b0;
    sb.push_back('{cyc + LAT, 4'b0110, 4'b0000});
    ticks(10);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drained observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
